// File: rtl/vga_pkg.sv
// Shared screen geometry, plot payload and arbiter state encoding for the VGA plot path.
package vga_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COL_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] colour;
    } plot_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index last_i, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  pick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand   = '0;
        // k = NREQ lands back on last_i, so the previous owner has lowest priority
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDX_W'((32'(last_i) + 32'(k)) % 32'(NREQ));
            if (!any_o && req_i[cand]) begin
                pick_o[cand] = 1'b1;
                idx_o        = cand;
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin sharing of the single VGA adapter plot port among NREQ drawing engines,
// with one-cycle registered plot output, off-screen clipping and saturating debug counters.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    input  logic [NREQ*X_W-1:0]   req_x,
    input  logic [NREQ*Y_W-1:0]   req_y,
    input  logic [NREQ*COL_W-1:0] req_colour,
    input  logic [NREQ-1:0]       req_plot,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [COL_W-1:0]      vga_colour,
    output logic                  vga_plot,
    output logic                  busy,
    output logic [CNT_W-1:0]      plot_count,
    output logic [7:0]            clip_count
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             busy_q, busy_d;
    plot_t            vga_q, vga_d;
    logic             vga_plot_q, vga_plot_d;
    logic [CNT_W-1:0] plot_cnt_q, plot_cnt_d;
    logic [7:0]       clip_cnt_q, clip_cnt_d;

    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    plot_t            sel;
    logic             accept;
    logic             on_screen;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= IDX_W'(NREQ - 1);
            busy_q     <= 1'b0;
            vga_q      <= '0;
            vga_plot_q <= 1'b0;
            plot_cnt_q <= '0;
            clip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            vga_q      <= vga_d;
            vga_plot_q <= vga_plot_d;
            plot_cnt_q <= plot_cnt_d;
            clip_cnt_q <= clip_cnt_d;
        end
    end

    // Grant FSM: a grant is held until its owner drops req, never pre-empted
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick;
                    last_d  = pick_idx;
                    busy_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!req[last_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Plot path: mux the granted engine, clip off-screen points, count outcomes
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_q[i]) begin
                sel.x      = req_x[i*X_W +: X_W];
                sel.y      = req_y[i*Y_W +: Y_W];
                sel.colour = req_colour[i*COL_W +: COL_W];
            end
        end
        accept    = |(gnt_q & req_plot);
        on_screen = (sel.x < X_W'(SCREEN_W)) && (sel.y < Y_W'(SCREEN_H));

        vga_plot_d = accept && on_screen;
        vga_d      = vga_plot_d ? sel : vga_q;

        plot_cnt_d = plot_cnt_q;
        clip_cnt_d = clip_cnt_q;
        if (accept && on_screen && (plot_cnt_q != '1)) begin
            plot_cnt_d = plot_cnt_q + CNT_W'(1);
        end
        if (accept && !on_screen && (clip_cnt_q != '1)) begin
            clip_cnt_d = clip_cnt_q + 8'(1);
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign vga_x      = vga_q.x;
    assign vga_y      = vga_q.y;
    assign vga_colour = vga_q.colour;
    assign vga_plot   = vga_plot_q;
    assign plot_count = plot_cnt_q;
    assign clip_count = clip_cnt_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: expected plots queued at drive time, popped when vga_plot fires.
module tb_vga_plot_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } exp_plot_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ*8-1:0]  req_x = '0;
    logic [NREQ*7-1:0]  req_y = '0;
    logic [NREQ*3-1:0]  req_colour = '0;
    logic [NREQ-1:0]    req_plot = '0;
    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot;
    logic               busy;
    logic [CNT_W-1:0]   plot_count;
    logic [7:0]         clip_count;

    int                 n_tests = 0;
    int                 n_fail  = 0;
    exp_plot_t          sb[$];
    bit                 due = 1'b0;
    logic [NREQ-1:0]    exp_gnt = '0;
    logic [CNT_W-1:0]   exp_plot_cnt = '0;
    logic [7:0]         exp_clip_cnt = '0;

    vga_plot_arbiter #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_plot   (req_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .plot_count (plot_count),
        .clip_count (clip_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample 1ns after the edge, compare vga_plot and pop the scoreboard
    task automatic tick();
        exp_plot_t e;
        @(posedge clk);
        #1;
        chk("vga_plot", 32'(vga_plot), 32'(due));
        if (vga_plot === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(0), 32'(1));
            end else begin
                e = sb.pop_front();
                chk("vga_x", 32'(vga_x), 32'(e.x));
                chk("vga_y", 32'(vga_y), 32'(e.y));
                chk("vga_colour", 32'(vga_colour), 32'(e.c));
            end
        end
        due = 1'b0;
    endtask

    task automatic drive(input int eng, input int x, input int y, input int c);
        exp_plot_t e;
        req_plot = '0;
        req_plot[eng] = 1'b1;
        req_x[eng*8 +: 8]      = 8'(x);
        req_y[eng*7 +: 7]      = 7'(y);
        req_colour[eng*3 +: 3] = 3'(c);
        if (exp_gnt[eng]) begin
            if (x < 160 && y < 120) begin
                e.x = 8'(x); e.y = 7'(y); e.c = 3'(c);
                sb.push_back(e);
                due = 1'b1;
                if (exp_plot_cnt != {CNT_W{1'b1}}) exp_plot_cnt = exp_plot_cnt + CNT_W'(1);
            end else begin
                if (exp_clip_cnt != 8'hff) exp_clip_cnt = exp_clip_cnt + 8'(1);
            end
        end
    endtask

    task automatic check_gnt(input logic [NREQ-1:0] g);
        exp_gnt = g;
        chk("gnt", 32'(gnt), 32'(g));
        chk("busy", 32'(busy), 32'(g != '0));
    endtask

    task automatic check_counts();
        chk("plot_count", 32'(plot_count), 32'(exp_plot_cnt));
        chk("clip_count", 32'(clip_count), 32'(exp_clip_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        due = 1'b0;
        exp_plot_cnt = '0;
        exp_clip_cnt = '0;
        exp_gnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        #3;
        check_gnt('0);
        check_counts();
        chk("rst_vga_plot", 32'(vga_plot), 32'(0));
        chk("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: single engine, one plot
        req = 3'b001;
        tick();
        check_gnt(3'b001);
        drive(0, 5, 7, 3);
        tick();
        req_plot = '0;
        check_counts();
        req = '0;
        tick();
        check_gnt('0);

        // 2: three engines round-robin, each drops req with its 4th plot
        do_reset();
        req = 3'b111;
        for (int e = 0; e < 3; e++) begin
            tick();
            check_gnt(3'(1 << e));
            for (int p = 0; p < 4; p++) begin
                drive(e, 10 * e + p, 20 + p, p);
                if (p == 3) req[e] = 1'b0;
                tick();
            end
            req_plot = '0;
            check_gnt('0);
        end
        chk("plot_count_12", 32'(plot_count), 32'(12));
        check_counts();

        // 3: clipping on both axes and the last on-screen pixel
        req = 3'b010;
        tick();
        check_gnt(3'b010);
        drive(1, 160, 0, 1);
        tick();
        drive(1, 10, 120, 2);
        tick();
        drive(1, 159, 119, 5);
        tick();
        req_plot = '0;
        chk("clip_count_2", 32'(clip_count), 32'(2));
        check_counts();

        // 4: non-granted engine strobes are dropped
        req = '0;
        tick();
        check_gnt('0);
        req = 3'b001;
        tick();
        check_gnt(3'b001);
        drive(2, 20, 20, 4);
        tick();
        req_plot = '0;
        check_counts();

        // 5: async reset right after an accepted plot
        drive(0, 1, 2, 3);
        tick();
        req_plot = '0;
        rst = 1'b1;
        #1;
        sb.delete();
        due = 1'b0;
        exp_plot_cnt = '0;
        exp_clip_cnt = '0;
        check_gnt('0);
        chk("rst_mid_vga_plot", 32'(vga_plot), 32'(0));
        check_counts();
        #2;
        rst = 1'b0;
        req = 3'b110;
        tick();
        check_gnt(3'b010);
        req = '0;
        tick();
        check_gnt('0);

        // 6: plot counter saturation
        req = 3'b001;
        tick();
        check_gnt(3'b001);
        for (int i = 0; i < 65540; i++) begin
            drive(0, i % 160, i % 120, i % 8);
            tick();
        end
        req_plot = '0;
        req = '0;
        chk("plot_count_sat", 32'(plot_count), 32'(65535));
        check_counts();
        tick();
        check_gnt('0);
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
